// File: rtl/seq_divider.sv
// seq_divider: multi-cycle signed 32-bit restoring divider, quotient to Zlowout, remainder to Zhighout
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] Zlowout,
  output logic [WIDTH-1:0] Zhighout
);
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, FIX = 2'd2, DONE = 2'd3;
  localparam int CW = $clog2(WIDTH) + 1;
  logic [1:0] state;
  logic [CW-1:0] count;
  logic [WIDTH-1:0] rem, quot, dvs, a_abs, b_abs;
  logic [WIDTH:0] shifted, diff;
  logic sign_q, sign_r, accept, last;
  // operand magnitudes, one restoring trial subtraction, and start acceptance
  always_comb begin
    a_abs = A[WIDTH-1] ? -A : A;
    b_abs = B[WIDTH-1] ? -B : B;
    shifted = {rem, quot[WIDTH-1]};
    diff = shifted - {1'b0, dvs};
    accept = start && (state == IDLE || state == DONE);
    last = count == CW'(WIDTH - 1);
  end
  assign busy = state == RUN || state == FIX;
  assign done = state == DONE;
  // control FSM and datapath: accept, iterate, sign-fix, report
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state <= IDLE;
      count <= '0;
      rem <= '0;
      quot <= '0;
      dvs <= '0;
      sign_q <= 1'b0;
      sign_r <= 1'b0;
      div_by_zero <= 1'b0;
      Zlowout <= '0;
      Zhighout <= '0;
    end else if (accept) begin
      if (B == '0) begin
        Zlowout <= '1;
        Zhighout <= A;
        div_by_zero <= 1'b1;
        state <= DONE;
      end else begin
        rem <= '0;
        quot <= a_abs;
        dvs <= b_abs;
        sign_q <= A[WIDTH-1] ^ B[WIDTH-1];
        sign_r <= A[WIDTH-1];
        count <= '0;
        div_by_zero <= 1'b0;
        state <= RUN;
      end
    end else if (state == RUN) begin
      rem <= diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
      quot <= {quot[WIDTH-2:0], ~diff[WIDTH]};
      count <= count + 1'b1;
      state <= last ? FIX : RUN;
    end else if (state == FIX) begin
      Zlowout <= sign_q ? -quot : quot;
      Zhighout <= sign_r ? -rem : rem;
      state <= DONE;
    end else if (state == DONE) begin
      state <= IDLE;
    end
  end
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed and random checks of seq_divider against a signed-arithmetic model
module tb_seq_divider;
  logic clock = 1'b0, clear = 1'b1, start = 1'b0;
  logic [31:0] A = '0, B = '0;
  logic busy, done, div_by_zero;
  logic [31:0] Zlowout, Zhighout;
  int cmp = 0, errs = 0;

  seq_divider dut (
    .clock(clock), .clear(clear), .start(start), .A(A), .B(B),
    .busy(busy), .done(done), .div_by_zero(div_by_zero),
    .Zlowout(Zlowout), .Zhighout(Zhighout)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] q, output logic [31:0] r);
    longint sa = $signed(a);
    longint sb = $signed(b);
    if (b == 0) begin
      q = '1;
      r = a;
    end else begin
      q = 32'(sa / sb);
      r = 32'(sa % sb);
    end
  endfunction

  task automatic divide(input logic [31:0] a, input logic [31:0] b, input bit b2b);
    logic [31:0] q, r;
    int n, nb;
    model(a, b, q, r);
    if (b2b) check("b2b_done_before", done, 1);
    else @(negedge clock);
    A = a;
    B = b;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    A = $urandom;
    B = $urandom;
    n = 1;
    nb = 0;
    while (!done && n < 40) begin
      if (busy) nb++;
      @(negedge clock);
      n++;
    end
    check("latency", 32'(n), b == 0 ? 32'd1 : 32'd34);
    check("busy_cycles", 32'(nb), b == 0 ? 32'd0 : 32'd33);
    check("busy_at_done", busy, 0);
    check("quotient", Zlowout, q);
    check("remainder", Zhighout, r);
    check("div_by_zero", div_by_zero, b == 0);
  endtask

  initial begin
    int dn;
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_dbz", div_by_zero, 0);
    check("rst_lo", Zlowout, 0);
    check("rst_hi", Zhighout, 0);
    repeat (2) @(negedge clock);
    clear = 1'b0;
    divide(32'd100, 32'd7, 0);
    divide(32'hFFFFFF9C, 32'd7, 0);
    divide(32'd100, 32'hFFFFFFF9, 0);
    divide(32'hFFFFFF9C, 32'hFFFFFFF9, 0);
    divide(32'd5, 32'd0, 0);
    divide(32'd100, 32'd7, 1);
    divide(32'h80000000, 32'hFFFFFFFF, 0);
    divide(32'h7FFFFFFF, 32'd1, 0);
    divide(32'h80000000, 32'd1, 0);
    divide(32'd3, 32'h80000000, 0);
    divide(32'd0, 32'hFFFFFFFF, 0);
    for (int i = 0; i < 20; i++) begin
      logic [31:0] ra, rb;
      ra = $urandom;
      rb = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(1, 20)) : $urandom;
      if (i == 7) rb = 32'd0;
      divide(ra, rb, 0);
    end
    @(negedge clock);
    A = 32'd100;
    B = 32'd7;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (9) @(negedge clock);
    A = 32'd9;
    B = 32'd3;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (22) @(negedge clock);
    check("ign_not_done_early", done, 0);
    @(negedge clock);
    check("ign_done", done, 1);
    check("ign_lo", Zlowout, 14);
    check("ign_hi", Zhighout, 2);
    @(negedge clock);
    A = 32'd100;
    B = 32'd7;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (19) @(negedge clock);
    check("clr_busy_before", busy, 1);
    clear = 1'b1;
    #1;
    check("clr_busy", busy, 0);
    check("clr_done", done, 0);
    check("clr_dbz", div_by_zero, 0);
    check("clr_lo", Zlowout, 0);
    check("clr_hi", Zhighout, 0);
    repeat (2) @(negedge clock);
    clear = 1'b0;
    dn = 0;
    repeat (40) begin
      @(negedge clock);
      if (done || busy) dn++;
    end
    check("clr_no_done", 32'(dn), 0);
    divide(32'd100, 32'd7, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
    $finish;
  end
endmodule
